// File: rtl/multi_mode_counter_pkg.sv
// multi_mode_counter_pkg
//   Shared types for multi_mode_counter.
//   mode_e  : count mode latched on start (one-shot or periodic auto-reload).
//   state_e : controller state (IDLE, RUN).
package multi_mode_counter_pkg;

  typedef enum logic [0:0] {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_e;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_RUN
  } state_e;

endpackage

// File: rtl/multi_mode_counter.sv
// multi_mode_counter
//   Counts enabled clock cycles up to a programmable terminal value N and
//   emits a one-cycle `counted` pulse at terminal. One-shot or periodic
//   (auto-reload) operation with start / stop / restart control.
//
// Parameters
//   WIDTH          width of the count register and of count_num
//   DEFAULT_COUNT  terminal value latched at reset (1 .. 2^WIDTH-1)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start        pulse: latch count_num/mode, clear count, enter RUN
//   stop         pulse: abort count, return to IDLE (wins over start)
//   mode         0 = one-shot, 1 = periodic; sampled on start
//   count_num    terminal count N; sampled on start
//   tick_en      count enable
//   counted      registered one-cycle terminal pulse
//   busy         registered, high while in RUN
//   count_value  current count 0 .. N-1
//   cfg_err      one-cycle pulse when start is sampled with count_num == 0
//
// Optional (macro MULTI_MODE_COUNTER_IRQ_EN defined)
//   irq_clr      clears irq and overrun
//   irq          sticky, set by a terminal (set wins over clear)
//   overrun      sticky, set when a terminal fires while irq is already set
module multi_mode_counter
  import multi_mode_counter_pkg::*;
#(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned DEFAULT_COUNT = 10000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] count_num,
  input  logic             tick_en,
`ifdef MULTI_MODE_COUNTER_IRQ_EN
  input  logic             irq_clr,
  output logic             irq,
  output logic             overrun,
`endif
  output logic             counted,
  output logic             busy,
  output logic [WIDTH-1:0] count_value,
  output logic             cfg_err
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             counted_q, counted_d;
  logic             busy_q, busy_d;
  logic             cfg_err_q, cfg_err_d;

  logic             start_ok;
  logic             at_terminal;

  assign start_ok    = start && (count_num != '0);
  // N-1 is always derived from the latched N; n_q is never zero.
  assign at_terminal = (count_q == (n_q - 1'b1));

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    n_d       = n_q;
    count_d   = count_q;
    counted_d = 1'b0;
    cfg_err_d = start && (count_num == '0);

    case (state_q)
      ST_IDLE: begin
        if (!stop && start_ok) begin
          n_d     = count_num;
          mode_d  = mode_e'(mode);
          count_d = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          // Stop beats both start and a coincident terminal.
          count_d = '0;
          state_d = ST_IDLE;
        end else if (start_ok) begin
          n_d     = count_num;
          mode_d  = mode_e'(mode);
          count_d = '0;
        end else if (tick_en) begin
          if (at_terminal) begin
            count_d   = '0;
            counted_d = 1'b1;
            if (mode_q == MODE_ONESHOT) begin
              state_d = ST_IDLE;
            end
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase

    // busy registered from next state so it falls with the one-shot pulse.
    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_ONESHOT;
      n_q       <= WIDTH'(DEFAULT_COUNT);
      count_q   <= '0;
      counted_q <= 1'b0;
      busy_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      n_q       <= n_d;
      count_q   <= count_d;
      counted_q <= counted_d;
      busy_q    <= busy_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign counted     = counted_q;
  assign busy        = busy_q;
  assign count_value = count_q;
  assign cfg_err     = cfg_err_q;

`ifdef MULTI_MODE_COUNTER_IRQ_EN
  logic irq_q, irq_d;
  logic overrun_q, overrun_d;

  always_comb begin
    irq_d     = irq_q;
    overrun_d = overrun_q;
    if (irq_clr) begin
      irq_d     = 1'b0;
      overrun_d = 1'b0;
    end
    // Set is applied last so it wins over a same-cycle clear.
    if (counted_d) begin
      irq_d = 1'b1;
      if (irq_q) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      irq_q     <= irq_d;
      overrun_q <= overrun_d;
    end
  end

  assign irq     = irq_q;
  assign overrun = overrun_q;
`endif

endmodule
